// File: rtl/mc_pkg.sv
// Shared types for the multicycle controller: state codes, opcodes and datapath select encodings.
// The JAL state exists only when MC_JAL_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
`ifdef MC_JAL_EN
        S_JAL    = 4'd12,
`endif
        S_ERROR  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // States that wait on mem_ready and are therefore guarded by the timer.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// 8-bit stall counter: counts cycles spent waiting on memory, flags expiry when it reaches TIMEOUT.
// expired is registered-state derived (no combinational path from inc/clear).
module mc_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with per-memory-state mem_ready timeout into a sticky ERROR state.
// Moore outputs except FETCH IRWrite/PCWrite (= mem_ready); MC_JAL_EN adds the JAL state.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       error
);

    state_e state_q, state_d;
    logic   expired;
    logic   timer_clr;
    logic   timer_inc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (expired) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (expired) state_d = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (expired) state_d = S_ERROR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
`ifdef MC_JAL_EN
            S_JAL:    state_d = S_FETCH;
`endif
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Any transition restarts the stall count, so each wait state gets a full budget.
    assign timer_clr = (state_d != state_q);
    assign timer_inc = is_wait_state(state_q) && !mem_ready;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clr),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemToReg    = M2R_ALUOUT;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemToReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                RegDst   = RD_RA;
                MemToReg = M2R_PC;
                RegWrite = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset forces FETCH, whose mem_ready-driven strobes must not leak out meanwhile.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state = state_q;
    assign error = (state_q == S_ERROR);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15, mem_ready wait limit in cycles per memory state (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 OpCode  in  6  instruction opcode, driven from the instruction register.
REQ-005 mem_ready  in  1  memory access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1 each  datapath strobes/selects.
REQ-007 RegDst, MemToReg, ALUSrcB, ALUOp, PCSource  out  2 each  datapath selects.
REQ-008 state  out  4  current FSM state code; error  out  1  sticky fault flag.

Function
REQ-009 FSM shall have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL, ERROR.
REQ-010 Outputs shall be Moore, except IRWrite and PCWrite in FETCH, which equal mem_ready; every output not listed for a state shall be 0, never X.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; hold until mem_ready=1, then DECODE.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-013 DECODE next state: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, 000011->JAL, any other->ERROR.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if OpCode=100011, else MEMWR.
REQ-015 MEMRD: IorD=1, MemRead=1; hold until mem_ready=1, then MEMWB.
REQ-016 MEMWB: RegDst=00, MemToReg=01, RegWrite=1; next FETCH.
REQ-017 MEMWR: IorD=1, MemWrite=1; hold until mem_ready=1, then FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-019 ALUWB: RegDst=01, MemToReg=00, RegWrite=1; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
REQ-022 ADDIWB: RegDst=00, MemToReg=00, RegWrite=1; next FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-024 JAL: PCWrite=1, PCSource=10, RegDst=10, MemToReg=10, RegWrite=1; next FETCH.
REQ-025 Wait counter (8 bits) shall increment each cycle in FETCH/MEMRD/MEMWR while mem_ready=0, and clear on any state change.
REQ-026 When the counter equals TIMEOUT with mem_ready=0, next state shall be ERROR; mem_ready=1 in that same cycle wins and completes normally.
REQ-027 ERROR: all strobes 0, error=1; state held until reset.
REQ-028 Instruction latencies with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3 cycles.

Reset
REQ-029 reset=1 shall force state=FETCH, counter=0, error=0 immediately, regardless of clk.
REQ-030 While reset=1 all strobes shall be 0 (IRWrite/PCWrite gated low).
REQ-031 Reset asserted mid-instruction shall abandon it; first cycle after deassertion is FETCH.

Configuration
REQ-032 Macro MC_JAL_EN: when defined, OpCode 000011 in DECODE shall go to JAL per REQ-024.
REQ-033 Without MC_JAL_EN, state JAL shall not exist and OpCode 000011 shall go to ERROR.

Structure
REQ-034 Package mc_pkg shall hold the state enum (4-bit), opcode constants, and ALUOp/PCSource/MemToReg/RegDst encodings.
REQ-035 Wait counter with timeout compare shall be sub-module mc_wait_timer (inputs clk, reset, clear, inc; output expired).

Verification
REQ-036 reset pulse mid-MEMRD -> state=FETCH within the same cycle, error=0, MemRead=1 after release.
REQ-037 OpCode=100011, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 only in MEMWB, MemToReg=01.
REQ-038 OpCode=000000 with mem_ready low 3 cycles in FETCH -> FETCH held 4 cycles, IRWrite high once, then DECODE,EXEC,ALUWB.
REQ-039 mem_ready held 0 in MEMWR, TIMEOUT=15 -> ERROR after 16 cycles in MEMWR, error=1 until reset.
REQ-040 OpCode=000011 -> JAL with RegDst=10, MemToReg=10, PCWrite=1 if MC_JAL_EN; else ERROR.
REQ-041 OpCode=111111 -> ERROR from DECODE; all strobes 0 thereafter.
